// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug-of-War press arbiter.
package tow_pkg;

    // Arbiter phase/lockout states
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StDarkWatch = 2'd1,
        StArmed     = 2'd2,
        StLockout   = 2'd3
    } tow_state_e;

    // Player side; also the encoding of the simultaneous-press token
    typedef enum logic {
        SideLeft  = 1'b0,
        SideRight = 1'b1
    } tow_side_e;

    // Width of the optional per-player push statistics counters
    localparam int unsigned StatsW = 8;

endpackage

// File: rtl/tow_btn_sync.sv
// Button synchroniser plus rising-edge detector.
// The edge output is itself registered, so a button first high at clock edge k
// yields e_x high for the cycle after edge k+2 (with SYNC_STAGES = 2).
module tow_btn_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic e_x
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   e_q, e_d;

    // Shift chain, previous-value tracking and edge detection
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn};
        prev_d = sync_q[SYNC_STAGES-1];
        e_d    = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // State registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            e_q    <= e_d;
        end
    end

    assign e_x = e_q;

endmodule

// File: rtl/tow_press_arbiter.sv
// Tug-of-War button arbiter: turns the two player buttons into single-cycle
// push pulses, resolves simultaneous presses with a rotating token, applies a
// post-press lockout counted in slowen ticks and flags dark-phase false starts.
// Optional build macro TOW_PRESS_STATS_EN adds saturating per-player push
// counters (cnt_l, cnt_r) with a synchronous clear (stats_clr).
module tow_press_arbiter
    import tow_pkg::*;
#(
    parameter int unsigned LOCKOUT_TICKS = 2,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              dark,
    input  logic              play,
    input  logic              slowen,
    output logic              push_l,
    output logic              push_r,
    output logic              foul_l,
    output logic              foul_r,
`ifdef TOW_PRESS_STATS_EN
    input  logic              stats_clr,
    output logic [StatsW-1:0] cnt_l,
    output logic [StatsW-1:0] cnt_r,
`endif
    output logic              busy
);

    localparam int unsigned CntW = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LOCKOUT_TICKS);

    logic e_l, e_r;

    tow_btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_l (
        .clk(clk),
        .rst(rst),
        .btn(btn_l),
        .e_x(e_l)
    );

    tow_btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_r (
        .clk(clk),
        .rst(rst),
        .btn(btn_r),
        .e_x(e_r)
    );

    tow_state_e      state_q, state_d;
    tow_side_e       token_q, token_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            foul_lat_l_q, foul_lat_l_d;
    logic            foul_lat_r_q, foul_lat_r_d;
    logic            push_l_q, push_l_d;
    logic            push_r_q, push_r_d;
    logic            foul_l_q, foul_l_d;
    logic            foul_r_q, foul_r_d;

    // Phase sequencing, arbitration, lockout countdown and foul detection.
    // Phase changes take priority, so a push never survives a phase change.
    always_comb begin
        state_d      = state_q;
        token_d      = token_q;
        cnt_d        = cnt_q;
        foul_lat_l_d = foul_lat_l_q;
        foul_lat_r_d = foul_lat_r_q;
        push_l_d     = 1'b0;
        push_r_d     = 1'b0;
        foul_l_d     = 1'b0;
        foul_r_d     = 1'b0;

        if (!play && !dark) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (!play) begin
            state_d = StDarkWatch;
            cnt_d   = '0;
            if (state_q != StDarkWatch) begin
                // Fresh dark phase: every player may be flagged once again
                foul_lat_l_d = 1'b0;
                foul_lat_r_d = 1'b0;
            end else begin
                if (e_l && !foul_lat_l_q) begin
                    foul_l_d     = 1'b1;
                    foul_lat_l_d = 1'b1;
                end
                if (e_r && !foul_lat_r_q) begin
                    foul_r_d     = 1'b1;
                    foul_lat_r_d = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                StIdle, StDarkWatch: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    if (e_l && e_r) begin
                        // Tie: token holder wins, loser's edge is dropped
                        if (token_q == SideLeft) begin
                            push_l_d = 1'b1;
                            token_d  = SideRight;
                        end else begin
                            push_r_d = 1'b1;
                            token_d  = SideLeft;
                        end
                    end else begin
                        push_l_d = e_l;
                        push_r_d = e_r;
                    end
                    if ((e_l || e_r) && (LOCKOUT_TICKS != 0)) begin
                        state_d = StLockout;
                        cnt_d   = CntInit;
                    end
                end
                StLockout: begin
                    if (cnt_q == '0) begin
                        state_d = StArmed;
                    end else if (slowen) begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Arbiter state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            token_q      <= SideLeft;
            cnt_q        <= '0;
            foul_lat_l_q <= 1'b0;
            foul_lat_r_q <= 1'b0;
            push_l_q     <= 1'b0;
            push_r_q     <= 1'b0;
            foul_l_q     <= 1'b0;
            foul_r_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            token_q      <= token_d;
            cnt_q        <= cnt_d;
            foul_lat_l_q <= foul_lat_l_d;
            foul_lat_r_q <= foul_lat_r_d;
            push_l_q     <= push_l_d;
            push_r_q     <= push_r_d;
            foul_l_q     <= foul_l_d;
            foul_r_q     <= foul_r_d;
        end
    end

    assign push_l = push_l_q;
    assign push_r = push_r_q;
    assign foul_l = foul_l_q;
    assign foul_r = foul_r_q;
    assign busy   = (state_q == StLockout);

`ifdef TOW_PRESS_STATS_EN
    logic [StatsW-1:0] cnt_l_q, cnt_l_d;
    logic [StatsW-1:0] cnt_r_q, cnt_r_d;

    // Saturating push counters; clear wins over a same-cycle increment
    always_comb begin
        cnt_l_d = cnt_l_q;
        cnt_r_d = cnt_r_q;
        if (stats_clr) begin
            cnt_l_d = '0;
            cnt_r_d = '0;
        end else begin
            if (push_l_q && (cnt_l_q != '1)) begin
                cnt_l_d = cnt_l_q + StatsW'(1);
            end
            if (push_r_q && (cnt_r_q != '1)) begin
                cnt_r_d = cnt_r_q + StatsW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_l_q <= '0;
            cnt_r_q <= '0;
        end else begin
            cnt_l_q <= cnt_l_d;
            cnt_r_q <= cnt_r_d;
        end
    end

    assign cnt_l = cnt_l_q;
    assign cnt_r = cnt_r_q;
`endif

endmodule

// File: tb/tb_tow_press_arbiter.sv
// Self-checking bench for tow_press_arbiter (default parameters).
module tb_tow_press_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic btn_l, btn_r, dark, play, slowen;
    logic push_l, push_r, foul_l, foul_r, busy;
`ifdef TOW_PRESS_STATS_EN
    logic       stats_clr;
    logic [7:0] cnt_l, cnt_r;
`endif

    always #5 clk = ~clk;

    tow_press_arbiter dut (
        .clk(clk),
        .rst(rst),
        .btn_l(btn_l),
        .btn_r(btn_r),
        .dark(dark),
        .play(play),
        .slowen(slowen),
        .push_l(push_l),
        .push_r(push_r),
        .foul_l(foul_l),
        .foul_r(foul_r),
`ifdef TOW_PRESS_STATS_EN
        .stats_clr(stats_clr),
        .cnt_l(cnt_l),
        .cnt_r(cnt_r),
`endif
        .busy(busy)
    );

    typedef struct {
        logic dark, play, slowen, bl, br;
        logic pl, pr, fl, fr, busy;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl[NVEC];

    int errors = 0;
    int checks = 0;
    int seen_l = 0;
    int seen_r = 0;
    int seen_both = 0;

    function automatic vec_t mk(input logic [4:0] i, input logic [4:0] o);
        vec_t v;
        v.dark = i[4]; v.play = i[3]; v.slowen = i[2]; v.bl = i[1]; v.br = i[0];
        v.pl = o[4]; v.pr = o[3]; v.fl = o[2]; v.fr = o[1]; v.busy = o[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: outputs are sampled on the falling edge after the active edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (push_l) seen_l++;
        if (push_r) seen_r++;
        if (push_l && push_r) seen_both++;
    endtask

    task automatic clear_seen();
        seen_l = 0;
        seen_r = 0;
        seen_both = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_l = 1'b0; btn_r = 1'b0; dark = 1'b0; play = 1'b0; slowen = 1'b0;
`ifdef TOW_PRESS_STATS_EN
        stats_clr = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    // Step until a push appears; n = steps taken (0 if none within budget)
    task automatic wait_push(input int budget, output int n, output logic gl, output logic gr);
        n = 0; gl = 1'b0; gr = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (push_l || push_r) begin
                n = c; gl = push_l; gr = push_r;
                break;
            end
        end
    endtask

    // From the cycle of an accepted push: two slow ticks then back to ARMED
    task automatic end_lockout();
        btn_l = 1'b0; btn_r = 1'b0;
        slowen = 1'b1;
        step();
        step();
        slowen = 1'b0;
        step();
    endtask

    int   n;
    logic gl, gr;

    initial begin
        // {dark, play, slowen, btn_l, btn_r}  ->  {push_l, push_r, foul_l, foul_r, busy}
        tbl[0]  = mk(5'b01000, 5'b00000);  // enter ARMED
        tbl[1]  = mk(5'b01010, 5'b00000);  // btn_l first high at edge k
        tbl[2]  = mk(5'b01010, 5'b00000);
        tbl[3]  = mk(5'b01010, 5'b00000);
        tbl[4]  = mk(5'b01010, 5'b10001);  // push_l after edge k+3, LOCKOUT cnt=2
        tbl[5]  = mk(5'b01010, 5'b00001);
        tbl[6]  = mk(5'b01110, 5'b00001);  // cnt 2->1
        tbl[7]  = mk(5'b01110, 5'b00001);  // cnt 1->0
        tbl[8]  = mk(5'b01010, 5'b00000);  // back to ARMED
        tbl[9]  = mk(5'b10000, 5'b00000);  // dark phase
        tbl[10] = mk(5'b10001, 5'b00000);  // btn_r false start
        tbl[11] = mk(5'b10001, 5'b00000);
        tbl[12] = mk(5'b10001, 5'b00000);
        tbl[13] = mk(5'b10001, 5'b00010);  // foul_r
        tbl[14] = mk(5'b10000, 5'b00000);
        tbl[15] = mk(5'b10000, 5'b00000);
        tbl[16] = mk(5'b10001, 5'b00000);  // second false start, latched
        tbl[17] = mk(5'b10001, 5'b00000);
        tbl[18] = mk(5'b10001, 5'b00000);
        tbl[19] = mk(5'b10001, 5'b00000);
        tbl[20] = mk(5'b01000, 5'b00000);  // play
        tbl[21] = mk(5'b01001, 5'b00000);
        tbl[22] = mk(5'b01001, 5'b00000);
        tbl[23] = mk(5'b01001, 5'b00000);
        tbl[24] = mk(5'b01001, 5'b01001);  // push_r
        tbl[25] = mk(5'b01001, 5'b00001);

        do_reset();
        chk("reset push_l", push_l, 0);
        chk("reset push_r", push_r, 0);
        chk("reset foul_l", foul_l, 0);
        chk("reset foul_r", foul_r, 0);
        chk("reset busy", busy, 0);

        for (int i = 0; i < NVEC; i++) begin
            dark = tbl[i].dark; play = tbl[i].play; slowen = tbl[i].slowen;
            btn_l = tbl[i].bl; btn_r = tbl[i].br;
            step();
            chk($sformatf("v%0d push_l", i), push_l, tbl[i].pl);
            chk($sformatf("v%0d push_r", i), push_r, tbl[i].pr);
            chk($sformatf("v%0d foul_l", i), foul_l, tbl[i].fl);
            chk($sformatf("v%0d foul_r", i), foul_r, tbl[i].fr);
            chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
        end

        // Held button: no repeat over 50 cycles, lockout expires meanwhile
        clear_seen();
        for (int c = 0; c < 50; c++) begin
            slowen = (c % 8 == 7);
            step();
        end
        slowen = 1'b0;
        chk("held no repeat", seen_l + seen_r, 0);
        chk("held busy end", busy, 0);

        // Lockout with slowen every 8 cycles
        btn_r = 1'b0;
        repeat (3) step();
        btn_l = 1'b1;
        wait_push(8, n, gl, gr);
        chk("lk push latency", n, 4);
        chk("lk push_l", gl, 1);
        btn_l = 1'b0;
        repeat (7) step();
        chk("lk busy pre tick1", busy, 1);
        slowen = 1'b1;
        step();
        slowen = 1'b0;
        chk("lk busy tick1", busy, 1);
        clear_seen();
        btn_r = 1'b1;
        repeat (7) step();
        slowen = 1'b1;
        step();
        slowen = 1'b0;
        chk("lk busy tick2", busy, 1);
        step();
        chk("lk busy after", busy, 0);
        chk("lk press ignored", seen_l + seen_r, 0);
        btn_r = 1'b0;
        repeat (3) step();
        btn_r = 1'b1;
        wait_push(8, n, gl, gr);
        chk("lk re-press latency", n, 4);
        chk("lk re-press push_r", gr, 1);
        end_lockout();

        // Phase drop mid-LOCKOUT
        btn_l = 1'b1;
        wait_push(8, n, gl, gr);
        chk("drop push_l", gl, 1);
        chk("drop busy before", busy, 1);
        play = 1'b0; dark = 1'b0;
        step();
        chk("drop busy after", busy, 0);
        chk("drop no push", push_l | push_r, 0);
        play = 1'b1; btn_l = 1'b0;
        repeat (3) step();
        btn_l = 1'b1;
        wait_push(8, n, gl, gr);
        chk("drop re-press latency", n, 4);
        chk("drop re-press push_l", gl, 1);

        // Asynchronous reset mid-LOCKOUT
        btn_l = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst push_l", push_l, 0);
        chk("arst busy", busy, 0);
        chk("arst foul", foul_l | foul_r, 0);
        step();
        rst = 1'b0;
        step();
        btn_l = 1'b1;
        wait_push(8, n, gl, gr);
        chk("arst press latency", n, 4);
        chk("arst press push_l", gl, 1);
        end_lockout();

        // Simultaneous presses: token starts left and rotates L, R, L
        clear_seen();
        for (int i = 0; i < 3; i++) begin
            btn_l = 1'b1; btn_r = 1'b1;
            wait_push(8, n, gl, gr);
            chk($sformatf("tie%0d push_l", i), gl, (i == 1) ? 0 : 1);
            chk($sformatf("tie%0d push_r", i), gr, (i == 1) ? 1 : 0);
            end_lockout();
        end
        chk("tie never both", seen_both, 0);

`ifdef TOW_PRESS_STATS_EN
        do_reset();
        chk("stats reset cnt_l", cnt_l, 0);
        play = 1'b1;
        step();
        clear_seen();
        for (int i = 0; i < 260; i++) begin
            btn_l = 1'b1;
            repeat (4) step();
            end_lockout();
        end
        chk("stats pushes", seen_l, 260);
        chk("stats cnt_l sat", cnt_l, 255);
        chk("stats cnt_r", cnt_r, 0);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("stats clr cnt_l", cnt_l, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
